// File: rtl/mux_buf_nto1_if.sv
// Bus bundle for the N:1 buffered mux: channel data, select control and status.
// The tri-state output q is kept as a plain port on the mux itself.
interface mux_buf_nto1_if #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] d;
  logic [SEL_W-1:0]          sel;
  logic                      sel_load;
  logic                      scan_en;
  logic                      oe;
  logic                      q_valid;
  logic [SEL_W-1:0]          cur_sel;
  logic                      wrap;
  logic                      sel_err;

  modport master (
    output d, sel, sel_load, scan_en, oe,
    input  q_valid, cur_sel, wrap, sel_err
  );

  modport slave (
    input  d, sel, sel_load, scan_en, oe,
    output q_valid, cur_sel, wrap, sel_err
  );
endinterface

// File: rtl/mux_buf_nto1.sv
// N:1 registered multiplexer with loadable/auto-scanning select register and
// a registered tri-state output buffer driving a shared bus.
module mux_buf_nto1 #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4
) (
  input  logic             clk,
  input  logic             rst,
  mux_buf_nto1_if.slave    bus,
  // q sits directly on the module boundary so the tri-state driver is a real port
  output logic [WIDTH-1:0] q
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  function automatic logic [SEL_W-1:0] next_chan(input logic [SEL_W-1:0] cur);
    next_chan = (cur == LAST_SEL) ? '0 : cur + 1'b1;
  endfunction

  logic [SEL_W-1:0] sel_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic [WIDTH-1:0] data_p1;
  logic [SEL_W-1:0] ch_p1;
  logic             cap_p1;
  logic             oe_p1;
  logic             wrap_p1;
  logic             err_p1;

  logic sel_ok;
  logic dwell_end;

  assign sel_ok    = {1'b0, bus.sel} < CH_LIM;
  assign dwell_end = (cnt_p0 == CNT_LAST);

  // stage p0 -> p1: select register update and data capture from the old select
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_p0  <= '0;
      cnt_p0  <= '0;
      data_p1 <= '0;
      ch_p1   <= '0;
      cap_p1  <= 1'b0;
      oe_p1   <= 1'b0;
      wrap_p1 <= 1'b0;
      err_p1  <= 1'b0;
    end else begin
      data_p1 <= bus.d[sel_p0*WIDTH +: WIDTH];
      ch_p1   <= sel_p0;
      cap_p1  <= 1'b1;
      oe_p1   <= bus.oe;
      wrap_p1 <= 1'b0;
      err_p1  <= 1'b0;
      if (bus.sel_load) begin
        // an out-of-range load freezes both select and dwell count
        if (sel_ok) begin
          sel_p0 <= bus.sel;
          cnt_p0 <= '0;
        end else begin
          err_p1 <= 1'b1;
        end
      end else if (bus.scan_en) begin
        if (dwell_end) begin
          cnt_p0  <= '0;
          sel_p0  <= next_chan(sel_p0);
          wrap_p1 <= (sel_p0 == LAST_SEL);
        end else begin
          cnt_p0 <= cnt_p0 + 1'b1;
        end
      end else begin
        cnt_p0 <= '0;
      end
    end
  end

  // stage p1 outputs
  assign q           = oe_p1 ? data_p1 : {WIDTH{1'bz}};
  assign bus.q_valid = cap_p1 & (ch_p1 == sel_p0);
  assign bus.cur_sel = sel_p0;
  assign bus.wrap    = wrap_p1;
  assign bus.sel_err = err_p1;
endmodule

// File: tb/tb_mux_buf_nto1.sv
// Bench for mux_buf_nto1: three configurations checked every cycle against a
// behavioural model, plus directed scenarios with literal expectations.
module tb_mux_buf_nto1;
  localparam int NI = 3;
  localparam int W_A [NI] = '{1, 8, 4};
  localparam int C_A [NI] = '{4, 3, 5};
  localparam int D_A [NI] = '{4, 2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] d_v    [NI];
  logic [2:0]  sel_v  [NI];
  logic        load_v [NI];
  logic        scan_v [NI];
  logic        oe_v   [NI];

  int total = 0;
  int bad   = 0;

  mux_buf_nto1_if #(.WIDTH(1), .CHANNELS(4)) if0 ();
  mux_buf_nto1_if #(.WIDTH(8), .CHANNELS(3)) if1 ();
  mux_buf_nto1_if #(.WIDTH(4), .CHANNELS(5)) if2 ();

  logic [0:0] q0;
  logic [7:0] q1;
  logic [3:0] q2;

  assign if0.d = d_v[0][3:0];   assign if0.sel = sel_v[0][1:0];
  assign if0.sel_load = load_v[0]; assign if0.scan_en = scan_v[0]; assign if0.oe = oe_v[0];
  assign if1.d = d_v[1][23:0];  assign if1.sel = sel_v[1][1:0];
  assign if1.sel_load = load_v[1]; assign if1.scan_en = scan_v[1]; assign if1.oe = oe_v[1];
  assign if2.d = d_v[2][19:0];  assign if2.sel = sel_v[2];
  assign if2.sel_load = load_v[2]; assign if2.scan_en = scan_v[2]; assign if2.oe = oe_v[2];

  mux_buf_nto1 #(.WIDTH(1), .CHANNELS(4), .DWELL(4)) u0 (.clk(clk), .rst(rst), .bus(if0), .q(q0));
  mux_buf_nto1 #(.WIDTH(8), .CHANNELS(3), .DWELL(2)) u1 (.clk(clk), .rst(rst), .bus(if1), .q(q1));
  mux_buf_nto1 #(.WIDTH(4), .CHANNELS(5), .DWELL(1)) u2 (.clk(clk), .rst(rst), .bus(if2), .q(q2));

  logic [7:0] qa [NI];
  logic [2:0] sa [NI];
  logic       va [NI];
  logic       wa [NI];
  logic       ea [NI];

  assign qa[0] = {7'b0, q0};  assign sa[0] = {1'b0, if0.cur_sel};
  assign qa[1] = q1;          assign sa[1] = {1'b0, if1.cur_sel};
  assign qa[2] = {4'b0, q2};  assign sa[2] = if2.cur_sel;
  assign va[0] = if0.q_valid; assign wa[0] = if0.wrap; assign ea[0] = if0.sel_err;
  assign va[1] = if1.q_valid; assign wa[1] = if1.wrap; assign ea[1] = if1.sel_err;
  assign va[2] = if2.q_valid; assign wa[2] = if2.wrap; assign ea[2] = if2.sel_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // A disabled buffer reads as Z on a 4-state simulator and as 0 on a 2-state one.
  task automatic chk_off(input string name, input int i);
    logic [7:0] zpat;
    for (int b = 0; b < 8; b++) zpat[b] = (b < W_A[i]) ? 1'bz : 1'b0;
    total++;
    if (!((qa[i] === 8'h00) || (qa[i] === zpat))) begin
      bad++;
      $display("FAIL %s: got %0h want bus released", name, qa[i]);
    end
  endtask

  // behavioural model state
  int       m_sel [NI];
  int       m_cnt [NI];
  int       m_qch [NI];
  int       m_qd  [NI];
  bit       m_cap [NI];
  bit       m_oe  [NI];
  bit       m_wrap[NI];
  bit       m_err [NI];
  bit       started = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_sel[i] = 0; m_cnt[i] = 0; m_qch[i] = 0; m_qd[i] = 0;
        m_cap[i] = 0; m_oe[i] = 0; m_wrap[i] = 0; m_err[i] = 0;
      end else begin
        m_qd[i]   = int'((d_v[i] >> (m_sel[i] * W_A[i])) & ((32'd1 << W_A[i]) - 1));
        m_qch[i]  = m_sel[i];
        m_cap[i]  = 1;
        m_oe[i]   = oe_v[i];
        m_wrap[i] = 0;
        m_err[i]  = 0;
        if (load_v[i]) begin
          if (int'(sel_v[i]) < C_A[i]) begin
            m_sel[i] = int'(sel_v[i]);
            m_cnt[i] = 0;
          end else begin
            m_err[i] = 1;
          end
        end else if (scan_v[i]) begin
          if (m_cnt[i] == D_A[i] - 1) begin
            m_cnt[i]  = 0;
            m_wrap[i] = (m_sel[i] == C_A[i] - 1);
            m_sel[i]  = (m_sel[i] + 1) % C_A[i];
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end
    end
    started = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("m%0d cur_sel", i), 32'(sa[i]), 32'(m_sel[i]));
      chk($sformatf("m%0d q_valid", i), 32'(va[i]), 32'(m_cap[i] && (m_qch[i] == m_sel[i])));
      chk($sformatf("m%0d wrap", i), 32'(wa[i]), 32'(m_wrap[i]));
      chk($sformatf("m%0d sel_err", i), 32'(ea[i]), 32'(m_err[i]));
      if (m_oe[i]) chk($sformatf("m%0d q", i), 32'(qa[i]), 32'(m_qd[i]));
      else         chk_off($sformatf("m%0d q_off", i), i);
    end
  end

  int wc;
  int seq3 [7] = '{0, 0, 1, 1, 2, 2, 0};
  logic [7:0] dat3 [3] = '{8'h0A, 8'h0B, 8'h0C};
  int par1 [4] = '{0, 1, 0, 1};

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      d_v[i] = '0; sel_v[i] = '0; load_v[i] = 1'b0; scan_v[i] = 1'b0; oe_v[i] = 1'b1;
    end
    @(negedge clk);
    chk("rst cur_sel", 32'(sa[1]), 32'd0);
    chk("rst q_valid", 32'(va[1]), 32'd0);
    chk_off("rst q", 1);
    @(negedge clk);
    rst = 1'b0;

    // 4:1, one bit per channel, manual loads
    d_v[0] = 32'b1010;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel_v[0] = 3'(s); load_v[0] = 1'b1;
      @(negedge clk);
      load_v[0] = 1'b0;
      chk($sformatf("t1 cur_sel %0d", s), 32'(sa[0]), 32'(s));
      if (s != 0) chk($sformatf("t1 valid low %0d", s), 32'(va[0]), 32'd0);
      @(negedge clk);
      chk($sformatf("t1 q %0d", s), 32'(qa[0]), 32'(par1[s]));
      chk($sformatf("t1 valid %0d", s), 32'(va[0]), 32'd1);
      repeat (8) @(negedge clk);
    end

    // 3 channels, dwell 2 scan
    d_v[1] = 32'h000C0B0A;
    sel_v[1] = 3'd0; load_v[1] = 1'b1; scan_v[1] = 1'b1;
    @(negedge clk);
    load_v[1] = 1'b0;
    chk("t3 seq 0", 32'(sa[1]), 32'd0);
    wc = 0;
    for (int k = 1; k < 7; k++) begin
      @(negedge clk);
      wc += int'(wa[1]);
      chk($sformatf("t3 seq %0d", k), 32'(sa[1]), 32'(seq3[k]));
      chk($sformatf("t3 q %0d", k), 32'(qa[1]), 32'(dat3[seq3[k-1]]));
    end
    chk("t3 wrap last", 32'(wa[1]), 32'd1);
    chk("t3 wrap count", 32'(wc), 32'd1);

    // out-of-range load, then load colliding with a scan advance
    sel_v[1] = 3'd3; load_v[1] = 1'b1;
    @(negedge clk);
    load_v[1] = 1'b0;
    chk("t4 sel_err", 32'(ea[1]), 32'd1);
    chk("t4 cur_sel held", 32'(sa[1]), 32'd0);
    chk("t4 q held", 32'(qa[1]), 32'h0A);
    @(negedge clk);
    chk("t4 sel_err drop", 32'(ea[1]), 32'd0);
    chk("t4 cnt held", 32'(sa[1]), 32'd0);
    sel_v[1] = 3'd2; load_v[1] = 1'b1;
    @(negedge clk);
    load_v[1] = 1'b0;
    chk("t4 load wins", 32'(sa[1]), 32'd2);
    @(negedge clk);
    chk("t4 cnt cleared", 32'(sa[1]), 32'd2);
    @(negedge clk);
    chk("t4 wrap after load", 32'(sa[1]), 32'd0);
    chk("t4 wrap pulse", 32'(wa[1]), 32'd1);

    // reset in the middle of a scan
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t2 cur_sel", 32'(sa[1]), 32'd0);
    chk("t2 q_valid", 32'(va[1]), 32'd0);
    chk("t2 wrap", 32'(wa[1]), 32'd0);
    chk_off("t2 q", 1);
    @(negedge clk);
    chk("t2 valid back", 32'(va[1]), 32'd1);
    chk("t2 q back", 32'(qa[1]), 32'h0A);

    // output enable toggle on a fixed channel
    scan_v[1] = 1'b0; sel_v[1] = 3'd1; load_v[1] = 1'b1;
    @(negedge clk);
    load_v[1] = 1'b0;
    @(negedge clk);
    chk("t5 q on", 32'(qa[1]), 32'h0B);
    oe_v[1] = 1'b0;
    @(negedge clk);
    chk_off("t5 q off", 1);
    oe_v[1] = 1'b1;
    @(negedge clk);
    chk("t5 q on again", 32'(qa[1]), 32'h0B);

    // 5 channels, dwell 1
    d_v[2] = 32'h00043210;
    sel_v[2] = 3'd7; load_v[2] = 1'b1;
    @(negedge clk);
    chk("t6 sel_err", 32'(ea[2]), 32'd1);
    chk("t6 cur_sel held", 32'(sa[2]), 32'd0);
    sel_v[2] = 3'd0; scan_v[2] = 1'b1;
    @(negedge clk);
    load_v[2] = 1'b0;
    wc = 0;
    for (int k = 1; k < 12; k++) begin
      @(negedge clk);
      wc += int'(wa[2]);
      chk($sformatf("t6 seq %0d", k), 32'(sa[2]), 32'(k % 5));
      chk($sformatf("t6 q_valid %0d", k), 32'(va[2]), 32'd0);
    end
    chk("t6 wrap count", 32'(wc), 32'd2);

    repeat (3) @(negedge clk);
    if (!started) chk("model never ran", 32'd0, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
